// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: latches the decoded ALU control word, the operands and the
// writeback/memory controls, with stall hold, flush bubble, sticky halt and sticky control-error flag.
module id_ex_latch #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_invA,
  input  logic                  id_invB,
  input  logic                  id_sign,
  input  logic                  id_cin,
  input  logic                  id_passA,
  input  logic                  id_passB,
  input  logic [2:0]            id_aluControl,
  input  logic [DATA_WIDTH-1:0] id_opA,
  input  logic [DATA_WIDTH-1:0] id_opB,
  input  logic [DATA_WIDTH-1:0] id_stData,
  input  logic [REG_W-1:0]      id_wrReg,
  input  logic                  id_regWrite,
  input  logic                  id_memRead,
  input  logic                  id_memWrite,
  input  logic                  id_halt,
  output logic                  ex_invA,
  output logic                  ex_invB,
  output logic                  ex_sign,
  output logic                  ex_cin,
  output logic                  ex_passA,
  output logic                  ex_passB,
  output logic [2:0]            ex_aluControl,
  output logic [DATA_WIDTH-1:0] ex_opA,
  output logic [DATA_WIDTH-1:0] ex_opB,
  output logic [DATA_WIDTH-1:0] ex_stData,
  output logic [REG_W-1:0]      ex_wrReg,
  output logic                  ex_regWrite,
  output logic                  ex_memRead,
  output logic                  ex_memWrite,
  output logic                  ex_halt,
  output logic                  ex_valid,
  output logic                  halted,
  output logic                  ctrl_err
);

  // Handshake: no ready path. id_valid qualifies the decode word on each edge; stall holds
  // this register and the decode stage must hold id_* stable; flush squashes to a bubble.
  logic illegal;
  logic take_bubble;
  logic take_load;

  always_comb begin
    illegal     = (id_passA & id_passB) | (id_passB & (id_aluControl != 3'b000));
    take_bubble = flush | (~stall & ~id_valid);
    take_load   = ~flush & ~stall & id_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_invA       <= 1'b0;
      ex_invB       <= 1'b0;
      ex_sign       <= 1'b0;
      ex_cin        <= 1'b0;
      ex_passA      <= 1'b0;
      ex_passB      <= 1'b0;
      ex_aluControl <= 3'b000;
      ex_opA        <= '0;
      ex_opB        <= '0;
      ex_stData     <= '0;
      ex_wrReg      <= '0;
      ex_regWrite   <= 1'b0;
      ex_memRead    <= 1'b0;
      ex_memWrite   <= 1'b0;
      ex_halt       <= 1'b0;
      ex_valid      <= 1'b0;
      halted        <= 1'b0;
      ctrl_err      <= 1'b0;
    end else if (!halted) begin
      if (take_bubble) begin
        // Bubble: everything zero; halted and ctrl_err are sticky and untouched.
        ex_invA       <= 1'b0;
        ex_invB       <= 1'b0;
        ex_sign       <= 1'b0;
        ex_cin        <= 1'b0;
        ex_passA      <= 1'b0;
        ex_passB      <= 1'b0;
        ex_aluControl <= 3'b000;
        ex_opA        <= '0;
        ex_opB        <= '0;
        ex_stData     <= '0;
        ex_wrReg      <= '0;
        ex_regWrite   <= 1'b0;
        ex_memRead    <= 1'b0;
        ex_memWrite   <= 1'b0;
        ex_halt       <= 1'b0;
        ex_valid      <= 1'b0;
      end else if (take_load) begin
        ex_invA       <= id_invA;
        ex_invB       <= id_invB;
        ex_sign       <= id_sign;
        ex_cin        <= id_cin;
        ex_passA      <= id_passA;
        ex_passB      <= id_passB;
        ex_aluControl <= id_aluControl;
        ex_opA        <= id_opA;
        ex_opB        <= id_opB;
        ex_stData     <= id_stData;
        ex_wrReg      <= id_wrReg;
        ex_regWrite   <= id_regWrite;
        ex_memRead    <= id_memRead;
        ex_memWrite   <= id_memWrite;
        ex_halt       <= id_halt;
        ex_valid      <= 1'b1;
        halted        <= id_halt;
        ctrl_err      <= ctrl_err | illegal;
      end
    end
  end

endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

ID/EX pipeline register of the 5-stage 16-bit pipelined processor. It captures the ALU control word produced by the decode-stage ALU control decoder (invA, invB, sign, aluControl, cin, passA, passB), the two operands and the writeback/memory controls. It presents them to the execute stage one cycle later. It also implements stall (hold), flush (bubble insertion), sticky halt freeze, and a sticky illegal-control error flag.

## Interface
Parameters:
- DATA_WIDTH, 16, operand width
- REG_W, 3, register-file address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold current contents (from hazard unit)
- flush  in  1  replace next contents with bubble (branch/jump redirect)
- id_valid  in  1  decode stage presents a real instruction
- id_invA, id_invB, id_sign, id_cin, id_passA, id_passB  in  1 each  ALU control bits from decoder
- id_aluControl  in  3  ALU operation select
- id_opA, id_opB  in  DATA_WIDTH  ALU operands (opB already immediate-muxed)
- id_stData  in  DATA_WIDTH  store data
- id_wrReg  in  REG_W  destination register
- id_regWrite, id_memRead, id_memWrite, id_halt  in  1 each  downstream controls
- ex_* (same names, ex_ prefix)  out  same widths  registered copies
- ex_valid  out  1  register holds a real instruction
- halted  out  1  sticky; a valid HALT has been latched
- ctrl_err  out  1  sticky; illegal control word was latched

## Operation
- Register contents: every ex_* field, ex_valid, halted, ctrl_err.
- Bubble: all ex_* fields 0 and ex_valid 0. aluControl 000 with passB 0 is a harmless rotate whose result is discarded (regWrite/memWrite 0).
- Next-state priority, evaluated each rising edge:
  1. halted = 1: hold everything. flush and stall are ignored. Only rst exits.
  2. flush = 1: load bubble. This applies even when stall = 1, because flush outranks stall.
  3. stall = 1: hold all fields unchanged.
  4. id_valid = 0: load bubble.
  5. Otherwise: load all id_* fields and set ex_valid = 1.
- Load gating: when a bubble is loaded, every control bit is forced to 0 regardless of the id_* input values. Operand fields are also 0 in a bubble.
- halted: set on the edge that loads a valid instruction with id_halt = 1 (rule 5). ex_halt = 1 and ex_valid = 1 are retained while halted.
- ctrl_err: set on the rule-5 load of a word that is illegal, and then remains set until rst. A word is illegal if either condition holds:
  - id_passA and id_passB are both 1.
  - id_passB = 1 and id_aluControl ≠ 000.
- The word itself is still latched unchanged, and ctrl_err has no effect on the datapath.
- No arithmetic is performed; widths pass straight through with no extension.

## Timing
- rst asserted: all outputs go to 0 immediately (asynchronously), including halted and ctrl_err. Release is synchronous to clk; the first load happens on the first rising edge with rst = 0.
- Latency: exactly 1 cycle from id_* valid to ex_*. Outputs come directly from flops; there is no combinational path from inputs to outputs.
- Stall may last any number of cycles. Outputs are bit-stable throughout, and the decode stage must hold id_* stable.
- stall and flush asserted together: a bubble is loaded (the squashed instruction is lost by design).
- Reset mid-stall or mid-halt: outputs clear at once, and the stall/halt history is not retained.
- Consecutive flushes: one bubble per cycle. ex_valid stays 0 for every flushed cycle.

## Test plan
- Reset check:
  - Stimulus: drive random id_*, assert rst asynchronously between edges.
  - Required: all outputs 0 before the next edge. After release, the first edge latches id_*.
- Pass-through:
  - Stimulus: ADD word (aluControl=100, all control bits 0), opA=16'h1234, opB=16'h0F0F, wrReg=3, regWrite=1, id_valid=1.
  - Required: next cycle ex_opA=1234, ex_opB=0F0F, ex_aluControl=100, ex_wrReg=3, ex_valid=1.
- Stall then flush:
  - Stimulus: load SUB (invA=1, cin=1); hold stall=1 for 3 cycles with changing id_*; then assert stall=1 and flush=1 together.
  - Required: outputs frozen at SUB for 3 cycles, then all fields 0 with ex_valid=0.
- Invalid input:
  - Stimulus: id_valid=0 with id_regWrite=1, id_memWrite=1.
  - Required: ex_regWrite=0, ex_memWrite=0, ex_valid=0.
- Halt freeze:
  - Stimulus: valid id_halt=1, then flush=1 and new valid instructions for 4 cycles.
  - Required: halted=1, ex_halt=1, ex_valid=1 and all fields unchanged for those 4 cycles; rst clears halted.
- Control error:
  - Stimulus: latch a word with passA=1, passB=1; then latch a legal LBI (passB=1, aluControl=000).
  - Required: ctrl_err=1 after the first word and still 1 after the LBI; the LBI alone from reset leaves ctrl_err=0.
